// File: rtl/id_ex_stage_if.sv
// Bundles the ID-side operands/controls, the MEM/WB forward sources, the hazard
// controls and the EX-side outputs of the ID/EX stage.
interface id_ex_stage_if #(
  parameter int DW = 32,
  parameter int RW = 5,
  parameter int CW = 4
);
  logic          Stall;
  logic          Flush;
  logic          ID_Valid;
  logic [CW-1:0] ID_ALUControl;
  logic [DW-1:0] ID_ReadData1;
  logic [DW-1:0] ID_ReadData2;
  logic [DW-1:0] ID_Imm;
  logic [4:0]    ID_Shamt;
  logic [RW-1:0] ID_Rs;
  logic [RW-1:0] ID_Rt;
  logic [RW-1:0] ID_Rd;
  logic          ID_ALUSrc;
  logic          ID_ShiftSrc;
  logic          ID_RegDst;
  logic          ID_RegWrite;
  logic          ID_MemRead;
  logic          ID_MemWrite;
  logic          ID_MemToReg;
  logic          MEM_RegWrite;
  logic [RW-1:0] MEM_WriteReg;
  logic [DW-1:0] MEM_ALUResult;
  logic          WB_RegWrite;
  logic [RW-1:0] WB_WriteReg;
  logic [DW-1:0] WB_WriteData;
  logic [CW-1:0] EX_ALUControl;
  logic [DW-1:0] EX_A;
  logic [DW-1:0] EX_B;
  logic [DW-1:0] EX_StoreData;
  logic [RW-1:0] EX_WriteReg;
  logic          EX_Valid;
  logic          EX_RegWrite;
  logic          EX_MemRead;
  logic          EX_MemWrite;
  logic          EX_MemToReg;
  logic          LoadUseHazard;

  modport master (
    output Stall, Flush, ID_Valid, ID_ALUControl, ID_ReadData1, ID_ReadData2,
           ID_Imm, ID_Shamt, ID_Rs, ID_Rt, ID_Rd, ID_ALUSrc, ID_ShiftSrc,
           ID_RegDst, ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg,
           MEM_RegWrite, MEM_WriteReg, MEM_ALUResult,
           WB_RegWrite, WB_WriteReg, WB_WriteData,
    input  EX_ALUControl, EX_A, EX_B, EX_StoreData, EX_WriteReg, EX_Valid,
           EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, LoadUseHazard
  );

  modport slave (
    input  Stall, Flush, ID_Valid, ID_ALUControl, ID_ReadData1, ID_ReadData2,
           ID_Imm, ID_Shamt, ID_Rs, ID_Rt, ID_Rd, ID_ALUSrc, ID_ShiftSrc,
           ID_RegDst, ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg,
           MEM_RegWrite, MEM_WriteReg, MEM_ALUResult,
           WB_RegWrite, WB_WriteReg, WB_WriteData,
    output EX_ALUControl, EX_A, EX_B, EX_StoreData, EX_WriteReg, EX_Valid,
           EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, LoadUseHazard
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding into the EX-stage ALU
// and load-use hazard detection back towards ID.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5,
  parameter int CW = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic          valid;
    logic [CW-1:0] aluc;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [4:0]    shamt;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] wreg;
    logic          alusrc;
    logic          shiftsrc;
    logic          regwrite;
    logic          memread;
    logic          memwrite;
    logic          memtoreg;
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [DW-1:0] fwd_rs_s;
  logic [DW-1:0] fwd_rt_s;

  // MEM beats WB; register 0 and bubbles never take a forward.
  always_comb begin
    fwd_rs_s = state_q.rs_data;
    if (state_q.valid && (state_q.rs != {RW{1'b0}}) && bus.MEM_RegWrite &&
        (bus.MEM_WriteReg == state_q.rs)) begin
      fwd_rs_s = bus.MEM_ALUResult;
    end else if (state_q.valid && (state_q.rs != {RW{1'b0}}) && bus.WB_RegWrite &&
                 (bus.WB_WriteReg == state_q.rs)) begin
      fwd_rs_s = bus.WB_WriteData;
    end else begin
      fwd_rs_s = state_q.rs_data;
    end
  end

  // Same selection for the rt operand.
  always_comb begin
    fwd_rt_s = state_q.rt_data;
    if (state_q.valid && (state_q.rt != {RW{1'b0}}) && bus.MEM_RegWrite &&
        (bus.MEM_WriteReg == state_q.rt)) begin
      fwd_rt_s = bus.MEM_ALUResult;
    end else if (state_q.valid && (state_q.rt != {RW{1'b0}}) && bus.WB_RegWrite &&
                 (bus.WB_WriteReg == state_q.rt)) begin
      fwd_rt_s = bus.WB_WriteData;
    end else begin
      fwd_rt_s = state_q.rt_data;
    end
  end

  // Next state: flush to bubble, stall keeps forwarded data alive, else load from ID.
  always_comb begin
    state_d = state_q;
    if (bus.Flush) begin
      state_d = '0;
    end else if (bus.Stall) begin
      state_d.rs_data = fwd_rs_s;
      state_d.rt_data = fwd_rt_s;
    end else begin
      state_d.valid    = bus.ID_Valid;
      state_d.aluc     = bus.ID_ALUControl;
      state_d.rs_data  = bus.ID_ReadData1;
      state_d.rt_data  = bus.ID_ReadData2;
      state_d.imm      = bus.ID_Imm;
      state_d.shamt    = bus.ID_Shamt;
      state_d.rs       = bus.ID_Rs;
      state_d.rt       = bus.ID_Rt;
      state_d.wreg     = bus.ID_RegDst ? bus.ID_Rd : bus.ID_Rt;
      state_d.alusrc   = bus.ID_ALUSrc;
      state_d.shiftsrc = bus.ID_ShiftSrc;
      state_d.regwrite = bus.ID_RegWrite;
      state_d.memread  = bus.ID_MemRead;
      state_d.memwrite = bus.ID_MemWrite;
      state_d.memtoreg = bus.ID_MemToReg;
    end
  end

  // Stage register with synchronous reset to a bubble.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign bus.EX_ALUControl = state_q.aluc;
  assign bus.EX_A          = state_q.shiftsrc ? fwd_rt_s : fwd_rs_s;
  assign bus.EX_B          = state_q.shiftsrc ? {{(DW-5){1'b0}}, state_q.shamt}
                           : (state_q.alusrc ? state_q.imm : fwd_rt_s);
  assign bus.EX_StoreData  = fwd_rt_s;
  assign bus.EX_WriteReg   = state_q.wreg;
  assign bus.EX_Valid      = state_q.valid;
  assign bus.EX_RegWrite   = state_q.regwrite;
  assign bus.EX_MemRead    = state_q.memread;
  assign bus.EX_MemWrite   = state_q.memwrite;
  assign bus.EX_MemToReg   = state_q.memtoreg;

  assign bus.LoadUseHazard = bus.ID_Valid & state_q.valid & state_q.memread &
                             (state_q.wreg != {RW{1'b0}}) &
                             ((bus.ID_Rs == state_q.wreg) | (bus.ID_Rt == state_q.wreg));

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: reset, forwarding priority, r0, operand
// select, stall capture, load-use detection and flush/reset bubbles.
module tb_id_ex_stage;
  logic Clk;
  logic Reset;
  int   n_cmp;
  int   n_bad;

  id_ex_stage_if #(.DW(32), .RW(5), .CW(4)) bus ();

  id_ex_stage #(.DW(32), .RW(5), .CW(4)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_id();
    bus.Stall = 1'b0;         bus.Flush = 1'b0;
    bus.ID_Valid = 1'b0;      bus.ID_ALUControl = 4'b0000;
    bus.ID_ReadData1 = 32'h0; bus.ID_ReadData2 = 32'h0;
    bus.ID_Imm = 32'h0;       bus.ID_Shamt = 5'd0;
    bus.ID_Rs = 5'd0;         bus.ID_Rt = 5'd0;          bus.ID_Rd = 5'd0;
    bus.ID_ALUSrc = 1'b0;     bus.ID_ShiftSrc = 1'b0;    bus.ID_RegDst = 1'b0;
    bus.ID_RegWrite = 1'b0;   bus.ID_MemRead = 1'b0;
    bus.ID_MemWrite = 1'b0;   bus.ID_MemToReg = 1'b0;
    bus.MEM_RegWrite = 1'b0;  bus.MEM_WriteReg = 5'd0;   bus.MEM_ALUResult = 32'h0;
    bus.WB_RegWrite = 1'b0;   bus.WB_WriteReg = 5'd0;    bus.WB_WriteData = 32'h0;
  endtask

  task automatic test_reset();
    clear_id();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    n_cmp++; if (bus.EX_Valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0b want 0", bus.EX_Valid); end
    n_cmp++; if (bus.EX_A !== 32'h0) begin n_bad++; $display("FAIL reset_a got %h want 0", bus.EX_A); end
    n_cmp++; if (bus.EX_B !== 32'h0) begin n_bad++; $display("FAIL reset_b got %h want 0", bus.EX_B); end
    n_cmp++; if (bus.EX_ALUControl !== 4'b0000) begin n_bad++; $display("FAIL reset_aluc got %b want 0000", bus.EX_ALUControl); end
    n_cmp++; if (bus.EX_WriteReg !== 5'd0 || bus.EX_RegWrite !== 1'b0 || bus.EX_MemRead !== 1'b0)
      begin n_bad++; $display("FAIL reset_ctrl got wr=%0d rw=%0b mr=%0b want 0", bus.EX_WriteReg, bus.EX_RegWrite, bus.EX_MemRead); end
  endtask

  task automatic test_add();
    clear_id();
    bus.ID_Valid = 1'b1; bus.ID_Rs = 5'd5; bus.ID_ReadData1 = 32'd7;
    bus.ID_Rt = 5'd6; bus.ID_ReadData2 = 32'd3; bus.ID_Rd = 5'd10;
    bus.ID_RegDst = 1'b1; bus.ID_RegWrite = 1'b1;
    tick();
    n_cmp++; if (bus.EX_A !== 32'd7) begin n_bad++; $display("FAIL add_a got %h want 7", bus.EX_A); end
    n_cmp++; if (bus.EX_B !== 32'd3) begin n_bad++; $display("FAIL add_b got %h want 3", bus.EX_B); end
    n_cmp++; if (bus.EX_Valid !== 1'b1 || bus.EX_RegWrite !== 1'b1)
      begin n_bad++; $display("FAIL add_ctrl got v=%0b rw=%0b want 1 1", bus.EX_Valid, bus.EX_RegWrite); end
    n_cmp++; if (bus.EX_WriteReg !== 5'd10) begin n_bad++; $display("FAIL add_wreg got %0d want 10", bus.EX_WriteReg); end
    n_cmp++; if (bus.EX_StoreData !== 32'd3) begin n_bad++; $display("FAIL add_store got %h want 3", bus.EX_StoreData); end
  endtask

  task automatic test_forward();
    clear_id();
    bus.ID_Valid = 1'b1; bus.ID_Rs = 5'd8; bus.ID_ReadData1 = 32'h11;
    bus.ID_Rt = 5'd8; bus.ID_ReadData2 = 32'h11; bus.ID_ALUControl = 4'b0110;
    tick();
    bus.MEM_RegWrite = 1'b1; bus.MEM_WriteReg = 5'd8; bus.MEM_ALUResult = 32'h55;
    bus.WB_RegWrite = 1'b1; bus.WB_WriteReg = 5'd8; bus.WB_WriteData = 32'h99;
    #1;
    n_cmp++; if (bus.EX_A !== 32'h55) begin n_bad++; $display("FAIL fwd_mem_prio got %h want 55", bus.EX_A); end
    n_cmp++; if (bus.EX_StoreData !== 32'h55) begin n_bad++; $display("FAIL fwd_mem_rt got %h want 55", bus.EX_StoreData); end
    n_cmp++; if (bus.EX_ALUControl !== 4'b0110) begin n_bad++; $display("FAIL fwd_aluc got %b want 0110", bus.EX_ALUControl); end
    bus.MEM_RegWrite = 1'b0;
    #1;
    n_cmp++; if (bus.EX_A !== 32'h99) begin n_bad++; $display("FAIL fwd_wb got %h want 99", bus.EX_A); end
    bus.WB_WriteReg = 5'd9;
    #1;
    n_cmp++; if (bus.EX_A !== 32'h11) begin n_bad++; $display("FAIL fwd_none got %h want 11", bus.EX_A); end
  endtask

  task automatic test_zero_reg();
    clear_id();
    bus.ID_Valid = 1'b1; bus.ID_Rs = 5'd0; bus.ID_Rt = 5'd0;
    tick();
    bus.MEM_RegWrite = 1'b1; bus.MEM_WriteReg = 5'd0; bus.MEM_ALUResult = 32'hFF;
    bus.WB_RegWrite = 1'b1; bus.WB_WriteReg = 5'd0; bus.WB_WriteData = 32'hEE;
    #1;
    n_cmp++; if (bus.EX_B !== 32'h0) begin n_bad++; $display("FAIL r0_b got %h want 0", bus.EX_B); end
    n_cmp++; if (bus.EX_A !== 32'h0) begin n_bad++; $display("FAIL r0_a got %h want 0", bus.EX_A); end
  endtask

  task automatic test_shift_imm();
    clear_id();
    bus.ID_Valid = 1'b1; bus.ID_ShiftSrc = 1'b1; bus.ID_Rs = 5'd2; bus.ID_ReadData1 = 32'hDEAD;
    bus.ID_Rt = 5'd3; bus.ID_ReadData2 = 32'h1; bus.ID_Shamt = 5'd4; bus.ID_Imm = 32'h77;
    tick();
    n_cmp++; if (bus.EX_A !== 32'h1) begin n_bad++; $display("FAIL sll_a got %h want 1", bus.EX_A); end
    n_cmp++; if (bus.EX_B !== 32'h4) begin n_bad++; $display("FAIL sll_b got %h want 4", bus.EX_B); end
    bus.ID_ShiftSrc = 1'b0; bus.ID_ALUSrc = 1'b1; bus.ID_ReadData1 = 32'h10;
    bus.ID_Imm = 32'hFFFF_FFFC; bus.ID_Shamt = 5'd31;
    tick();
    n_cmp++; if (bus.EX_B !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL addi_b got %h want fffffffc", bus.EX_B); end
    n_cmp++; if (bus.EX_A !== 32'h10) begin n_bad++; $display("FAIL addi_a got %h want 10", bus.EX_A); end
    n_cmp++; if (bus.EX_StoreData !== 32'h1) begin n_bad++; $display("FAIL addi_store got %h want 1", bus.EX_StoreData); end
  endtask

  task automatic test_stall();
    clear_id();
    bus.ID_Valid = 1'b1; bus.ID_Rs = 5'd4; bus.ID_ReadData1 = 32'hAAAA; bus.ID_RegWrite = 1'b1;
    tick();
    bus.WB_RegWrite = 1'b1; bus.WB_WriteReg = 5'd4; bus.WB_WriteData = 32'h1234;
    bus.Stall = 1'b1;
    bus.ID_Rs = 5'd7; bus.ID_ReadData1 = 32'h7777; bus.ID_RegWrite = 1'b0;
    tick();
    bus.WB_RegWrite = 1'b0;
    #1;
    n_cmp++; if (bus.EX_A !== 32'h1234) begin n_bad++; $display("FAIL stall_capture got %h want 1234", bus.EX_A); end
    tick();
    n_cmp++; if (bus.EX_A !== 32'h1234 || bus.EX_RegWrite !== 1'b1)
      begin n_bad++; $display("FAIL stall_hold got a=%h rw=%0b want 1234 1", bus.EX_A, bus.EX_RegWrite); end
    bus.Stall = 1'b0;
    tick();
    n_cmp++; if (bus.EX_A !== 32'h7777 || bus.EX_RegWrite !== 1'b0)
      begin n_bad++; $display("FAIL stall_release got a=%h rw=%0b want 7777 0", bus.EX_A, bus.EX_RegWrite); end
  endtask

  task automatic test_load_use();
    clear_id();
    bus.ID_Valid = 1'b1; bus.ID_MemRead = 1'b1; bus.ID_RegWrite = 1'b1; bus.ID_MemToReg = 1'b1;
    bus.ID_Rs = 5'd1; bus.ID_Rt = 5'd9; bus.ID_Rd = 5'd12; bus.ID_RegDst = 1'b0;
    tick();
    bus.ID_MemRead = 1'b0; bus.ID_Rs = 5'd9; bus.ID_Rt = 5'd2;
    #1;
    n_cmp++; if (bus.EX_WriteReg !== 5'd9) begin n_bad++; $display("FAIL lw_wreg got %0d want 9", bus.EX_WriteReg); end
    n_cmp++; if (bus.LoadUseHazard !== 1'b1) begin n_bad++; $display("FAIL luh_rs got %0b want 1", bus.LoadUseHazard); end
    bus.ID_Rs = 5'd3; bus.ID_Rt = 5'd9;
    #1;
    n_cmp++; if (bus.LoadUseHazard !== 1'b1) begin n_bad++; $display("FAIL luh_rt got %0b want 1", bus.LoadUseHazard); end
    bus.ID_Valid = 1'b0;
    #1;
    n_cmp++; if (bus.LoadUseHazard !== 1'b0) begin n_bad++; $display("FAIL luh_idinv got %0b want 0", bus.LoadUseHazard); end
    bus.ID_Valid = 1'b1; bus.ID_Rt = 5'd4;
    #1;
    n_cmp++; if (bus.LoadUseHazard !== 1'b0) begin n_bad++; $display("FAIL luh_nomatch got %0b want 0", bus.LoadUseHazard); end
    bus.ID_Rt = 5'd9; bus.Stall = 1'b1; bus.Flush = 1'b1;
    tick();
    n_cmp++; if (bus.EX_Valid !== 1'b0 || bus.EX_MemRead !== 1'b0)
      begin n_bad++; $display("FAIL flush_bubble got v=%0b mr=%0b want 0 0", bus.EX_Valid, bus.EX_MemRead); end
    n_cmp++; if (bus.LoadUseHazard !== 1'b0) begin n_bad++; $display("FAIL flush_luh got %0b want 0", bus.LoadUseHazard); end
  endtask

  task automatic test_reset_mid_stall();
    clear_id();
    bus.ID_Valid = 1'b1; bus.ID_RegWrite = 1'b1; bus.ID_ALUControl = 4'b0010;
    tick();
    bus.Stall = 1'b1;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    n_cmp++; if (bus.EX_Valid !== 1'b0 || bus.EX_ALUControl !== 4'b0000)
      begin n_bad++; $display("FAIL rst_stall got v=%0b aluc=%b want 0 0000", bus.EX_Valid, bus.EX_ALUControl); end
  endtask

  task automatic test_back_to_back();
    clear_id();
    bus.ID_Valid = 1'b1; bus.ID_Rs = 5'd11; bus.ID_ReadData1 = 32'h100;
    tick();
    bus.ID_Rs = 5'd12; bus.ID_ReadData1 = 32'h200; bus.ID_MemWrite = 1'b1;
    n_cmp++; if (bus.EX_A !== 32'h100 || bus.EX_MemWrite !== 1'b0)
      begin n_bad++; $display("FAIL b2b_first got a=%h mw=%0b want 100 0", bus.EX_A, bus.EX_MemWrite); end
    tick();
    n_cmp++; if (bus.EX_A !== 32'h200 || bus.EX_MemWrite !== 1'b1)
      begin n_bad++; $display("FAIL b2b_second got a=%h mw=%0b want 200 1", bus.EX_A, bus.EX_MemWrite); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    Reset = 1'b0;
    clear_id();
    test_reset();
    test_add();
    test_forward();
    test_zero_reg();
    test_shift_imm();
    test_stall();
    test_load_use();
    test_reset_mid_stall();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus EX-stage operand forwarding for the 5-stage MIPS datapath.
- Captures decoded operands and control from ID each cycle.
- Resolves RAW hazards by forwarding from the MEM and WB stages.
- Drives ALUControl, A and B directly into the 32-bit ALU, and flags load-use hazards back to ID.

Parameters:
- DW, 32, datapath width.
- RW, 5, register index width.
- CW, 4, ALUControl width (matches ALU encoding; 4'b0000 = add).

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  synchronous, active-high
- Stall  in  1  hold stage contents
- Flush  in  1  replace stage contents with bubble
- ID_Valid  in  1  ID slot holds a real instruction
- ID_ALUControl  in  CW  ALU operation
- ID_ReadData1, ID_ReadData2  in  DW each  register-file rs/rt data
- ID_Imm  in  DW  sign/zero-extended immediate
- ID_Shamt  in  5  shift amount
- ID_Rs, ID_Rt, ID_Rd  in  RW each  register indices
- ID_ALUSrc, ID_ShiftSrc, ID_RegDst, ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg  in  1 each  decoded controls
- MEM_RegWrite  in  1; MEM_WriteReg  in  RW; MEM_ALUResult  in  DW  EX/MEM forward source
- WB_RegWrite  in  1; WB_WriteReg  in  RW; WB_WriteData  in  DW  MEM/WB forward source
- EX_ALUControl  out  CW  to ALU
- EX_A, EX_B  out  DW each  ALU operands
- EX_StoreData  out  DW  forwarded rt for sw
- EX_WriteReg  out  RW  destination register
- EX_Valid, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg  out  1 each
- LoadUseHazard  out  1  request ID stall

Behaviour:
- Registered state: valid, ALUControl, rs/rt data, imm, shamt, rs, rt, writereg, controls.
  - writereg = RegDst ? Rd : Rt, computed at capture.
- Priority per rising edge: Reset > Flush > Stall > load.
- Reset or Flush: all state cleared to 0, giving a bubble.
  - Bubble outputs: EX_Valid=0, all control outputs 0, EX_ALUControl=4'b0000, EX_WriteReg=0.
  - EX_A, EX_B, EX_StoreData are 0 unless a forward hits; forwarding is disabled when valid=0, so the reset values are 0.
- Load: every state field takes its ID_* value; latency is 1 cycle from ID to EX outputs.
- Stall: control, indices, imm and shamt hold. The rs/rt data registers capture the currently forwarded values, so forwarded data is not lost when MEM/WB advance.
- Forwarding (combinational from registered state), per source operand op in {rs, rt}:
  - If valid and idx!=0 and MEM_RegWrite and MEM_WriteReg==idx, use MEM_ALUResult.
  - Else if valid and idx!=0 and WB_RegWrite and WB_WriteReg==idx, use WB_WriteData.
  - Else use the registered data.
  - MEM has priority over WB. Register 0 is never forwarded.
- Operand select:
  - ShiftSrc=1: EX_A = fwd_rt, EX_B = {27'b0, shamt}.
  - Else: EX_A = fwd_rs, EX_B = ALUSrc ? imm : fwd_rt.
  - EX_StoreData = fwd_rt always.
- LoadUseHazard = ID_Valid & EX_Valid & EX_MemRead & (EX_WriteReg!=0) & (ID_Rs==EX_WriteReg | ID_Rt==EX_WriteReg).
  - Purely combinational; does not self-stall.
  - The hazard unit asserts Stall upstream and Flush here.
- Simultaneous Stall and Flush: Flush wins and the stage becomes a bubble.
- Reset mid-stall: the stage becomes a bubble on that edge.

Test Plan:
- Reset=1 for one edge, then ID_Valid=1, add with rs=5 (data 7), rt=6 (data 3), no forwards -> next cycle EX_A=7, EX_B=3, EX_ALUControl=0000, EX_Valid=1, EX_RegWrite=1.
- Load an instruction with rs=8; MEM_RegWrite=1, MEM_WriteReg=8, MEM_ALUResult=0x55; WB also writes reg 8 with 0x99 -> EX_A=0x55 (MEM priority). Drop MEM_RegWrite -> EX_A=0x99.
- rt=0 with MEM_RegWrite=1, MEM_WriteReg=0, MEM_ALUResult=0xFF -> EX_B equals registered data 0, no forward.
- sll: ShiftSrc=1, rt data 0x1, shamt=4 -> EX_A=0x1, EX_B=4. addi: ALUSrc=1, imm=0xFFFFFFFC -> EX_B=0xFFFFFFFC.
- Stall while a WB forward of 0x1234 to rs is active, then WB_RegWrite drops while the stall continues -> EX_A stays 0x1234. Release the stall -> the new ID instruction loads.
- EX holds lw with writereg=9, ID_Rs=9, ID_Valid=1 -> LoadUseHazard=1. Assert Flush and Stall together -> next cycle EX_Valid=0, EX_MemRead=0, LoadUseHazard=0.
